// File: rtl/ldpc_pkg.sv
// Shared types and constants for the serial LDPC min-sum decoder.
package ldpc_pkg;

    // Width of the per-frame iteration counter
    localparam int unsigned ITER_W = 7;

    // Default code: 3 checks over 6 variables; row k = bits [k*6 +: 6]
    localparam int unsigned N_BITS_DEF   = 6;
    localparam int unsigned N_CHECKS_DEF = 3;
    localparam logic [N_CHECKS_DEF*N_BITS_DEF-1:0] H_MATRIX_DEF =
        {6'b110001, 6'b011010, 6'b000111};

    // Scheduler states
    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRow,
        StCol,
        StSynd,
        StDone
    } state_e;

    // Counter width able to index n items, never below one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/synd_chk.sv
// Serial syndrome checker: holds the hard-decision word and walks the H rows one per cycle.
module synd_chk
    import ldpc_pkg::*;
#(
    parameter int unsigned                    N_BITS   = N_BITS_DEF,
    parameter int unsigned                    N_CHECKS = N_CHECKS_DEF,
    parameter logic [N_CHECKS*N_BITS-1:0]     H_MATRIX = H_MATRIX_DEF
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              i_load,
    input  logic [N_BITS-1:0] i_estimate,
    input  logic              i_step,
    output logic [N_BITS-1:0] o_estimate,
    output logic              o_pass,
    output logic              o_fail,
    output logic              o_last
);

    localparam int unsigned CNT_W = cnt_width(N_CHECKS);

    logic [N_BITS-1:0] est_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [N_BITS-1:0] h_rows [N_CHECKS];
    logic [N_BITS-1:0] row;
    logic              parity;

    // Split the flattened H into addressable rows
    for (genvar k = 0; k < N_CHECKS; k++) begin : g_rows
        assign h_rows[k] = H_MATRIX[k*N_BITS +: N_BITS];
    end

    // Parity of the current check against the latched estimate
    always_comb begin
        row    = h_rows[cnt_q];
        parity = ^(est_q & row);
    end

    assign o_estimate = est_q;
    assign o_fail     = parity;
    assign o_pass     = ~parity;
    assign o_last     = (cnt_q == CNT_W'(N_CHECKS - 1));

    // Latch a fresh estimate (restarting at check 0) or advance to the next check
    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            est_q <= '0;
            cnt_q <= '0;
        end else if (i_load) begin
            est_q <= i_estimate;
            cnt_q <= '0;
        end else if (i_step) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/iter_sched.sv
// Iteration scheduler: load -> (row -> col -> syndrome)* -> result, above the datapath controller.
module iter_sched
    import ldpc_pkg::*;
#(
    parameter int unsigned                N_BITS   = N_BITS_DEF,
    parameter int unsigned                N_CHECKS = N_CHECKS_DEF,
    parameter int unsigned                MAX_ITER = 10,
    parameter logic [N_CHECKS*N_BITS-1:0] H_MATRIX = H_MATRIX_DEF
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              i_val,
    output logic              o_busy,
    output logic              o_load_start,
    input  logic              i_load_done,
    output logic              o_row_start,
    input  logic              i_row_done,
    output logic              o_col_start,
    input  logic              i_col_done,
    input  logic [N_BITS-1:0] i_estimate,
    output logic [N_BITS-1:0] o_data,
    output logic              o_val,
    output logic              o_success,
    output logic [ITER_W-1:0] o_iter
);

    localparam logic [ITER_W-1:0] MAX_ITER_W = ITER_W'(MAX_ITER);

    state_e            state_q;
    logic              col_accept;
    logic              synd_step;
    logic [N_BITS-1:0] synd_est;
    logic              synd_pass;
    logic              synd_fail;
    logic              synd_last;

    // A done pulse in the first cycle of its state (start pulse still high) is ignored
    assign col_accept = (state_q == StCol) && i_col_done && !o_col_start;
    assign synd_step  = (state_q == StSynd) && synd_pass && !synd_last;
    assign o_busy     = (state_q != StIdle);

    synd_chk #(
        .N_BITS   (N_BITS),
        .N_CHECKS (N_CHECKS),
        .H_MATRIX (H_MATRIX)
    ) u_synd_chk (
        .clk        (clk),
        .xrst       (xrst),
        .i_load     (col_accept),
        .i_estimate (i_estimate),
        .i_step     (synd_step),
        .o_estimate (synd_est),
        .o_pass     (synd_pass),
        .o_fail     (synd_fail),
        .o_last     (synd_last)
    );

    // Scheduler FSM with registered start/valid pulses and result registers
    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            state_q      <= StIdle;
            o_load_start <= 1'b0;
            o_row_start  <= 1'b0;
            o_col_start  <= 1'b0;
            o_val        <= 1'b0;
            o_success    <= 1'b0;
            o_data       <= '0;
            o_iter       <= '0;
        end else begin
            o_load_start <= 1'b0;
            o_row_start  <= 1'b0;
            o_col_start  <= 1'b0;
            o_val        <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (i_val) begin
                        state_q      <= StLoad;
                        o_load_start <= 1'b1;
                        o_iter       <= '0;
                        o_success    <= 1'b0;
                        o_data       <= '0;
                    end
                end
                StLoad: begin
                    if (i_load_done && !o_load_start) begin
                        state_q     <= StRow;
                        o_row_start <= 1'b1;
                    end
                end
                StRow: begin
                    if (i_row_done && !o_row_start) begin
                        state_q     <= StCol;
                        o_col_start <= 1'b1;
                    end
                end
                StCol: begin
                    if (col_accept) begin
                        state_q <= StSynd;
                        o_iter  <= o_iter + ITER_W'(1);
                    end
                end
                StSynd: begin
                    // First failing check ends the scan
                    if (synd_fail) begin
                        if (o_iter < MAX_ITER_W) begin
                            state_q     <= StRow;
                            o_row_start <= 1'b1;
                        end else begin
                            state_q   <= StDone;
                            o_val     <= 1'b1;
                            o_success <= 1'b0;
                            o_data    <= synd_est;
                        end
                    end else if (synd_last) begin
                        state_q   <= StDone;
                        o_val     <= 1'b1;
                        o_success <= 1'b1;
                        o_data    <= synd_est;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_sched.sv
// Directed bench for iter_sched with the default 6x3 code and MAX_ITER = 4.
module tb_iter_sched;

    localparam int unsigned NB = 6;
    localparam int unsigned NC = 3;
    localparam int unsigned MI = 4;

    logic          clk = 1'b0;
    logic          xrst = 1'b1;
    logic          i_val = 1'b0;
    logic          i_load_done = 1'b0;
    logic          i_row_done = 1'b0;
    logic          i_col_done = 1'b0;
    logic [NB-1:0] i_estimate = '0;
    logic          o_busy;
    logic          o_load_start;
    logic          o_row_start;
    logic          o_col_start;
    logic [NB-1:0] o_data;
    logic          o_val;
    logic          o_success;
    logic [6:0]    o_iter;

    int checks = 0;
    int errors = 0;

    iter_sched #(
        .N_BITS   (NB),
        .N_CHECKS (NC),
        .MAX_ITER (MI)
    ) dut (
        .clk          (clk),
        .xrst         (xrst),
        .i_val        (i_val),
        .o_busy       (o_busy),
        .o_load_start (o_load_start),
        .i_load_done  (i_load_done),
        .o_row_start  (o_row_start),
        .i_row_done   (i_row_done),
        .o_col_start  (o_col_start),
        .i_col_done   (i_col_done),
        .i_estimate   (i_estimate),
        .o_data       (o_data),
        .o_val        (o_val),
        .o_success    (o_success),
        .o_iter       (o_iter)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait gap cycles after a start pulse, then pulse the matching done for one cycle
    task automatic phase(input int which, input int gap);
        repeat (gap) step();
        case (which)
            0:       i_load_done = 1'b1;
            1:       i_row_done  = 1'b1;
            default: i_col_done  = 1'b1;
        endcase
        step();
        i_load_done = 1'b0;
        i_row_done  = 1'b0;
        i_col_done  = 1'b0;
    endtask

    task automatic start_frame();
        i_val = 1'b1;
        step();
        i_val = 1'b0;
    endtask

    // Cycles until o_val, bounded
    task automatic wait_val(output int n);
        n = 0;
        while (o_val !== 1'b1 && n < 20) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;

        // Reset state
        step();
        step();
        check("rst_busy", o_busy, 0);
        check("rst_load_start", o_load_start, 0);
        check("rst_row_start", o_row_start, 0);
        check("rst_col_start", o_col_start, 0);
        check("rst_val", o_val, 0);
        check("rst_data", o_data, 0);
        check("rst_success", o_success, 0);
        check("rst_iter", o_iter, 0);
        xrst = 1'b0;
        step();

        // Clean decode
        start_frame();
        check("t1_load_start", o_load_start, 1);
        check("t1_busy", o_busy, 1);
        step();
        check("t1_load_start_once", o_load_start, 0);
        phase(0, 2);
        check("t1_row_start", o_row_start, 1);
        phase(1, 3);
        check("t1_col_start", o_col_start, 1);
        i_estimate = 6'b000000;
        phase(2, 3);
        check("t1_iter_in_synd", o_iter, 1);
        wait_val(n);
        check("t1_latency", n, 3);
        check("t1_data", o_data, 6'b000000);
        check("t1_success", o_success, 1);
        check("t1_iter", o_iter, 1);
        step();
        check("t1_val_once", o_val, 0);
        check("t1_idle", o_busy, 0);
        check("t1_success_hold", o_success, 1);

        // Early exit at check 0 on iterations 1 and 2
        start_frame();
        check("t2_iter_clear", o_iter, 0);
        check("t2_success_clear", o_success, 0);
        phase(0, 3);
        phase(1, 3);
        i_estimate = 6'b000001;
        phase(2, 3);
        check("t2_synd_it1", o_row_start, 0);
        step();
        check("t2_row_restart_it1", o_row_start, 1);
        check("t2_iter_it1", o_iter, 1);
        phase(1, 3);
        phase(2, 3);
        step();
        check("t2_row_restart_it2", o_row_start, 1);
        check("t2_iter_it2", o_iter, 2);
        phase(1, 3);
        i_estimate = 6'b000000;
        phase(2, 3);
        wait_val(n);
        check("t2_latency", n, 3);
        check("t2_iter", o_iter, 3);
        check("t2_success", o_success, 1);
        check("t2_data", o_data, 6'b000000);
        step();

        // Failure at check 1
        start_frame();
        phase(0, 3);
        phase(1, 3);
        i_estimate = 6'b001000;
        phase(2, 3);
        step();
        check("t3_check0_pass", o_row_start, 0);
        check("t3_no_val", o_val, 0);
        step();
        check("t3_check1_fail", o_row_start, 1);
        i_estimate = 6'b000000;
        phase(1, 3);
        phase(2, 3);
        wait_val(n);
        check("t3_latency", n, 3);
        check("t3_iter", o_iter, 2);
        check("t3_success", o_success, 1);
        step();

        // Max iterations with a persistent check-0 failure
        start_frame();
        phase(0, 3);
        phase(1, 3);
        i_estimate = 6'b000001;
        for (int it = 1; it <= 3; it++) begin
            phase(2, 3);
            step();
            check($sformatf("t4_row_restart_it%0d", it), o_row_start, 1);
            phase(1, 3);
        end
        phase(2, 3);
        wait_val(n);
        check("t4_latency", n, 1);
        check("t4_iter", o_iter, 4);
        check("t4_success", o_success, 0);
        check("t4_data", o_data, 6'b000001);
        check("t4_busy_at_val", o_busy, 1);
        step();
        check("t4_busy_fall", o_busy, 0);
        check("t4_data_hold", o_data, 6'b000001);

        // Spurious inputs
        i_col_done = 1'b1;
        step();
        i_col_done = 1'b0;
        check("t5_idle_col_busy", o_busy, 0);
        check("t5_idle_col_iter", o_iter, 4);
        check("t5_idle_col_load", o_load_start, 0);
        start_frame();
        phase(0, 3);
        i_row_done = 1'b1;
        i_col_done = 1'b1;
        step();
        i_row_done = 1'b0;
        i_col_done = 1'b0;
        check("t5_row_first_cycle_done", o_col_start, 0);
        check("t5_row_no_restart", o_row_start, 0);
        step();
        i_col_done = 1'b1;
        step();
        i_col_done = 1'b0;
        check("t5_row_col_done", o_col_start, 0);
        check("t5_row_iter", o_iter, 0);
        i_row_done = 1'b1;
        step();
        i_row_done = 1'b0;
        check("t5_row_done_ok", o_col_start, 1);
        i_val = 1'b1;
        step();
        step();
        i_val = 1'b0;
        check("t5_col_val_ignored", o_load_start, 0);
        check("t5_col_busy", o_busy, 1);
        i_estimate = 6'b000000;
        i_col_done = 1'b1;
        step();
        i_col_done = 1'b0;
        wait_val(n);
        check("t5_latency", n, 3);
        check("t5_iter", o_iter, 1);
        step();

        // Reset mid-ROW, then a late row done
        start_frame();
        phase(0, 3);
        step();
        xrst = 1'b1;
        step();
        step();
        check("t6_rst_busy", o_busy, 0);
        check("t6_rst_row_start", o_row_start, 0);
        xrst = 1'b0;
        i_row_done = 1'b1;
        step();
        i_row_done = 1'b0;
        check("t6_late_done_col", o_col_start, 0);
        check("t6_late_done_busy", o_busy, 0);
        check("t6_iter", o_iter, 0);
        check("t6_success", o_success, 0);
        check("t6_data", o_data, 0);
        check("t6_val", o_val, 0);
        start_frame();
        check("t6_fresh_load", o_load_start, 1);
        check("t6_fresh_iter", o_iter, 0);
        phase(0, 3);
        phase(1, 3);
        i_estimate = 6'b000000;
        phase(2, 3);
        wait_val(n);
        check("t6_fresh_latency", n, 3);
        check("t6_fresh_iter_done", o_iter, 1);
        check("t6_fresh_success", o_success, 1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iter_sched.md
Name: iter_sched

Overview:
- Iteration scheduler for the serial LDPC min-sum decoder.
- Sequences each frame through four steps: LLR load, row (check-node) phase, column (variable-node) phase, then a serial syndrome check on the hard decisions.
- Repeats row/column iterations until the syndrome is zero or MAX_ITER is reached, then presents the decoded word.
- Sits above the row/column datapath controller; the datapath reports phase completion back with done pulses.

Parameters:
- N_BITS, 6, codeword length (variable nodes).
- N_CHECKS, 3, number of parity checks (H rows).
- MAX_ITER, 10, maximum iterations per frame (1..127).
- H_MATRIX, {6'b110001,6'b011010,6'b000111}, flattened H (N_CHECKS*N_BITS bits); row k = bits [k*N_BITS +: N_BITS], bit j = variable j.

Ports:
- clk  in  1  clock.
- xrst  in  1  asynchronous, active-high reset (xrst=1 resets).
- i_val  in  1  new frame LLRs valid on the datapath input; sampled in IDLE only.
- o_busy  out  1  high in every state except IDLE.
- o_load_start  out  1  one-cycle pulse: datapath loads λ into beta.
- i_load_done  in  1  load complete pulse.
- o_row_start  out  1  one-cycle pulse: start row phase.
- i_row_done  in  1  row phase complete pulse.
- o_col_start  out  1  one-cycle pulse: start column phase.
- i_col_done  in  1  column phase complete pulse; i_estimate valid this cycle.
- i_estimate  in  N_BITS  hard decisions (sign bits).
- o_data  out  N_BITS  decoded word.
- o_val  out  1  one-cycle result-valid pulse.
- o_success  out  1  1 = syndrome zero at termination.
- o_iter  out  7  completed iterations for the current/last frame.

Behaviour:
- States: IDLE, LOAD, ROW, COL, SYND, DONE.
- Reset: state=IDLE; all outputs 0; internal estimate register and check counter 0.
- IDLE:
  - i_val=1 → LOAD.
  - On the accept edge, clear o_iter, o_success and o_data.
- LOAD:
  - o_load_start=1 in the first LOAD cycle only.
  - i_load_done → ROW.
- ROW:
  - o_row_start=1 in the first cycle of each ROW entry.
  - i_row_done → COL.
- COL:
  - o_col_start=1 in the first cycle of each COL entry.
  - i_col_done → latch i_estimate, o_iter += 1, check counter k=0, go to SYND.
- Start pulses are registered Moore outputs and are re-asserted on every re-entry to their state.
- A done pulse is honoured only in its matching state and is ignored in all other states, including the first cycle of that state.
- i_val outside IDLE is ignored (no queuing).
- SYND: one check per cycle; parity_k = XOR-reduce(estimate AND H row k).
  - parity_k=1 and o_iter<MAX_ITER → ROW (early exit; no further checks evaluated).
  - parity_k=1 and o_iter==MAX_ITER → DONE with success=0.
  - parity_k=0 and k==N_CHECKS-1 → DONE with success=1.
  - parity_k=0 and k<N_CHECKS-1 → k+1.
  - A zero syndrome at iteration MAX_ITER reports success=1.
- DONE:
  - o_val=1 for exactly one cycle.
  - o_data = latched estimate; o_success per the SYND outcome.
  - → IDLE next cycle.
  - o_data, o_success and o_iter hold until the next accepted frame.
- Latency, i_col_done to o_val (passing syndrome): N_CHECKS+1 cycles. Failing at check k returns to ROW after k+1 SYND cycles.
- Counter widths:
  - o_iter is 7 bits and saturates logically via MAX_ITER.
  - Check counter is clog2(N_CHECKS) bits, minimum 1.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0; any done pulse arriving during or after reset is ignored until a new frame is accepted.

Decomposition:
- Shared package ldpc_pkg:
  - state enum (IDLE..DONE);
  - ITER_W=7;
  - default H_MATRIX constant, shared with the datapath address tables.
- One sub-module, synd_chk: holds the latched estimate and check counter, computes the per-check parity, and reports pass / fail / last.
- iter_sched instantiates synd_chk and owns the FSM and iteration counter.

Test Plan:
- Clean decode:
  - Stimulus: i_val; each done pulse 3 cycles after its start; i_estimate=6'b000000.
  - Required: exactly 3 SYND cycles, then o_val with o_data=000000, o_success=1, o_iter=1; o_val occurs 4 cycles after i_col_done.
- Early exit at check 0:
  - Stimulus: estimate=6'b000001 on iterations 1–2, then 000000.
  - Required: SYND lasts 1 cycle for iterations 1–2, o_row_start re-pulses; final o_iter=3, o_success=1.
- Failure at check 1:
  - Stimulus: estimate=6'b001000.
  - Required: check 0 passes, check 1 fails, return to ROW after 2 SYND cycles.
- Max iterations:
  - Stimulus: MAX_ITER=4; estimate always 6'b000001.
  - Required: o_val after 4th SYND with o_iter=4, o_success=0, o_data=000001; o_busy falls the following cycle.
- Spurious inputs:
  - Stimulus: i_col_done in IDLE and in ROW; i_val during COL.
  - Required: no state change, no extra start pulses, o_iter unchanged.
- Reset mid-ROW:
  - Stimulus: xrst=1 for 2 cycles during ROW, then an i_row_done pulse.
  - Required: all outputs 0, state IDLE, and the late done pulse is ignored; the next i_val starts a fresh frame with o_iter=0.
